// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   hz_state_e      : hazard FSM state encodings
//   REG_ZERO        : index of the hard-wired zero register
//   MD_LATENCY_DEF  : default mult/div occupancy in cycles
//   STAT_*          : slot indices of the optional statistics counters
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2
  } hz_state_e;

  localparam int unsigned REG_ZERO       = 0;
  localparam int unsigned MD_LATENCY_DEF = 32;

  localparam int unsigned NUM_STATS  = 4;
  localparam int unsigned STAT_LOAD  = 0;
  localparam int unsigned STAT_MD    = 1;
  localparam int unsigned STAT_MEM   = 2;
  localparam int unsigned STAT_FLUSH = 3;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: reloads LATENCY-1 on load_i, otherwise counts
// down to zero every cycle; busy_o is high while a HI/LO result is pending.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : a mult/div is issuing this cycle
//   busy_o   : HI/LO not yet valid
module md_busy_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic busy_o
);

  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload wins over decrement so a back-to-back issue restarts the wait.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LATENCY - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_controller.sv
// Central pipeline sequencer: merges data-memory wait, branch flush, mult/div
// busy and load-use hazards into per-stage write enables and bubble controls.
// Priority: memory freeze > branch flush > md stall > load-use stall.
//   inputs  : clk, rst (async, active-high), id_ex_memread, id_ex_rt,
//             if_id_rs, if_id_rt, if_id_md_use, md_start, branch_taken,
//             dmem_req, dmem_ready
//   outputs : pc_en, if_id_en, id_ex_en, ex_mem_en (stage write enables),
//             if_id_flush, id_ex_flush, mem_wb_flush (bubble insert),
//             md_busy, stat_load/stat_md/stat_mem/stat_flush
// Build option: define HAZARD_STATS_EN for saturating stall/flush counters;
// otherwise the stat_* ports read zero and no counter flops exist.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ex_memread,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_md_use,
  input  logic              md_start,
  input  logic              branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_flush,
  output logic              md_busy,
  output logic [STAT_W-1:0] stat_load,
  output logic [STAT_W-1:0] stat_md,
  output logic [STAT_W-1:0] stat_mem,
  output logic [STAT_W-1:0] stat_flush
);

  hz_state_e state_q;

  logic frz;
  logic brf;
  logic mds;
  logic lus;
  logic load_use_raw;
  logic md_load;

  // A load to the zero register never produces a usable value, so never stalls.
  assign load_use_raw = id_ex_memread && (id_ex_rt != REG_AW'(REG_ZERO)) &&
                        ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  // One-hot winning hazard for this cycle, resolved by priority.
  assign frz = dmem_req && !dmem_ready;
  assign brf = !frz && branch_taken;
  assign mds = !frz && !brf && md_busy && if_id_md_use;
  assign lus = !frz && !brf && !mds && load_use_raw;

  // A mult/div held in EX by a freeze re-presents later; only count it once it moves.
  assign md_load = md_start && ex_mem_en;

  md_busy_counter #(
    .LATENCY(MD_LATENCY)
  ) u_md_cnt (
    .clk   (clk),
    .rst   (rst),
    .load_i(md_load),
    .busy_o(md_busy)
  );

  // Hazard FSM: tracks whether the pipe is frozen on memory or waiting on HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (frz) state_q <= ST_MEM_WAIT;
          else if (mds) state_q <= ST_MD_WAIT;
        end
        ST_MD_WAIT: begin
          if (frz) state_q <= ST_MEM_WAIT;
          else if (!mds) state_q <= ST_RUN;
        end
        ST_MEM_WAIT: begin
          if (!frz) state_q <= mds ? ST_MD_WAIT : ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Per-stage enable/flush decode; reset holds every stage and bubbles the pipe.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (frz) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (brf) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (mds || lus) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [NUM_STATS-1:0]             stat_inc;
  logic [NUM_STATS-1:0][STAT_W-1:0] stat_q;

  assign stat_inc[STAT_LOAD]  = lus;
  assign stat_inc[STAT_MD]    = mds;
  assign stat_inc[STAT_MEM]   = frz;
  assign stat_inc[STAT_FLUSH] = brf;

  // Saturating event counters: stick at all-ones rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_STATS; i++) begin
        if (stat_inc[i] && (stat_q[i] != '1)) begin
          stat_q[i] <= stat_q[i] + STAT_W'(1);
        end
      end
    end
  end

  assign stat_load  = stat_q[STAT_LOAD];
  assign stat_md    = stat_q[STAT_MD];
  assign stat_mem   = stat_q[STAT_MEM];
  assign stat_flush = stat_q[STAT_FLUSH];
`else
  assign stat_load  = '0;
  assign stat_md    = '0;
  assign stat_mem   = '0;
  assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (REG_AW=5, MD_LATENCY=4, STAT_W=16).
// Output snapshot packing: {pc_en, if_id_en, id_ex_en, ex_mem_en,
//                           if_id_flush, id_ex_flush, mem_wb_flush, md_busy}
module tb_hazard_controller;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned STAT_W = 16;

  localparam logic [7:0] O_NORM  = 8'b1111_0000;
  localparam logic [7:0] O_LSTL  = 8'b0011_0100;
  localparam logic [7:0] O_MSTL  = 8'b0011_0101;
  localparam logic [7:0] O_BR    = 8'b1111_1100;
  localparam logic [7:0] O_FRZ   = 8'b0000_0010;
  localparam logic [7:0] O_RST   = 8'b0000_1110;

  typedef struct {
    logic              memread;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              md_use;
    logic              md_start;
    logic              br;
    logic              dreq;
    logic              drdy;
    logic [7:0]        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic id_ex_memread;
  logic [REG_AW-1:0] id_ex_rt, if_id_rs, if_id_rt;
  logic if_id_md_use, md_start, branch_taken, dmem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, md_busy;
  logic [STAT_W-1:0] stat_load, stat_md, stat_mem, stat_flush;
  logic [7:0] obs;

  int n_pass = 0;
  int n_total = 0;
  int e_load = 0, e_md = 0, e_mem = 0, e_flush = 0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_AW(REG_AW), .MD_LATENCY(4), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_md_use(if_id_md_use),
    .md_start(md_start), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .md_busy(md_busy),
    .stat_load(stat_load), .stat_md(stat_md), .stat_mem(stat_mem), .stat_flush(stat_flush)
  );

  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                if_id_flush, id_ex_flush, mem_wb_flush, md_busy};

  function automatic vec_t mk(input logic mr, input int ert, input int rs, input int rt,
                              input logic mu, input logic ms, input logic br,
                              input logic dq, input logic dr, input logic [7:0] exp);
    vec_t v;
    v.memread = mr;  v.ex_rt = REG_AW'(ert); v.rs = REG_AW'(rs); v.rt = REG_AW'(rt);
    v.md_use = mu;   v.md_start = ms;        v.br = br;
    v.dreq = dq;     v.drdy = dr;            v.exp = exp;
    return v;
  endfunction

  // Stats only exist when the counters are built in.
  function automatic int stat_exp(input int n);
`ifdef HAZARD_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk16(input string nm, input logic [STAT_W-1:0] act, input int exp);
    n_total++;
    if (act === STAT_W'(exp)) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply(input vec_t v);
    id_ex_memread = v.memread; id_ex_rt = v.ex_rt; if_id_rs = v.rs; if_id_rt = v.rt;
    if_id_md_use = v.md_use;   md_start = v.md_start; branch_taken = v.br;
    dmem_req = v.dreq;         dmem_ready = v.drdy;
  endtask

  // Drive at negedge, check 1ns later, tally the expected event, run through the posedge.
  task automatic step(input vec_t v, input string nm);
    apply(v);
    #1;
    chk8(nm, obs, v.exp);
    case (v.exp)
      O_FRZ:  e_mem++;
      O_BR:   e_flush++;
      O_MSTL: e_md++;
      O_LSTL: e_load++;
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic chk_stats(input string tag);
    chk16({tag, "_stat_load"},  stat_load,  stat_exp(e_load));
    chk16({tag, "_stat_md"},    stat_md,    stat_exp(e_md));
    chk16({tag, "_stat_mem"},   stat_mem,   stat_exp(e_mem));
    chk16({tag, "_stat_flush"}, stat_flush, stat_exp(e_flush));
  endtask

  vec_t tbl[12];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM);
    tbl[0]  = idle;                                        // idle pipe
    tbl[1]  = mk(1, 5, 5, 2, 0, 0, 0, 0, 0, O_LSTL);       // lw $5, ID rs=$5
    tbl[2]  = mk(1, 5, 3, 5, 0, 0, 0, 0, 0, O_LSTL);       // lw $5, ID rt=$5
    tbl[3]  = mk(1, 5, 6, 7, 0, 0, 0, 0, 0, O_NORM);       // no register match
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM);       // lw $0 never stalls
    tbl[5]  = mk(0, 5, 5, 5, 0, 0, 0, 0, 0, O_NORM);       // match but not a load
    tbl[6]  = mk(0, 0, 1, 2, 0, 0, 1, 0, 0, O_BR);         // taken branch
    tbl[7]  = mk(1, 5, 5, 0, 0, 0, 1, 0, 0, O_BR);         // branch beats load-use
    tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, O_FRZ);        // freeze, md_start ignored
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM);       // ready cycle not frozen
    tbl[10] = mk(1, 5, 5, 0, 0, 0, 1, 1, 0, O_FRZ);        // freeze beats branch+load
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_NORM);       // md use, nothing busy

    rst = 1'b1;
    apply(idle);
    #2;
    chk8("reset_outputs", obs, O_RST);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

    // mult/div issue at t0, mflo waits in ID t1..t3, proceeds t4
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_NORM), "md_t0");
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_MSTL), "md_t1");
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_MSTL), "md_t2");
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_MSTL), "md_t3");
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_NORM), "md_t4");

    // three frozen cycles with a branch held in EX, then the release cycle flushes
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ), $sformatf("frz_c%0d", i));
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR), "frz_release");

    chk_stats("run");

    // asynchronous reset while an mflo is stalled on HI/LO
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_NORM), "rmd_issue");
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_MSTL), "rmd_stall");
    #2;
    rst = 1'b1;
    #1;
    chk8("rmd_async_reset", obs, O_RST);
    e_load = 0; e_md = 0; e_mem = 0; e_flush = 0;
    chk_stats("rst");
    @(negedge clk);
    rst = 1'b0;
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_NORM), "rmd_after");
    chk_stats("post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
